// File: rtl/usb20sr_refdes_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// usb20sr_refdes_onchip_mem_arbiter
//
// Round-robin arbiter that shares the s2 port of the 32-bit on-chip memory
// between two Avalon-MM masters: m0 (ULPI RX DMA) and m1 (ULPI TX DMA).
// One transfer is accepted per clock. Read data is returned one cycle after
// the read is accepted. Addresses >= DEPTH never reach the memory. Such an
// access sets the sticky range_err flag, and a read of that kind still
// returns a zero data beat.
//
// Handshake (both masters): a master holds every request signal stable while
// its waitrequest is 1. A transfer is accepted in the cycle where it requests
// (read or write high) and its waitrequest is 0. Read data comes back with
// readdatavalid exactly one cycle after acceptance. There is no backpressure
// on the return path.
//
// Optional feature macro: ONCHIP_ARB_BURST_EN
//   Adds m0_burstcount/m1_burstcount. The first accepted beat of a burst locks
//   the grant to that master for burstcount accepted beats (0 counts as 1).
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   mX_address/read/write/byteenable/writedata   master request (X = 0, 1)
//   mX_waitrequest        stall to master X (1 unless accepted this cycle)
//   mX_readdata/valid     read return to master X
//   mem_*                 memory s2 port (address2, chipselect2, write2,
//                         byteenable2, writedata2, clken2, readdata2)
//   range_err             sticky out-of-range flag
//   err_clr               clears range_err (a new error wins the same cycle)
// ---------------------------------------------------------------------------
module usb20sr_refdes_onchip_mem_arbiter #(
  parameter int DEPTH   = 33750,
  parameter int ADDR_W  = 16,
  parameter int BURST_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
`ifdef ONCHIP_ARB_BURST_EN
  input  logic [BURST_W-1:0] m0_burstcount,
`endif
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
`ifdef ONCHIP_ARB_BURST_EN
  input  logic [BURST_W-1:0] m1_burstcount,
`endif
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              range_err,
  input  logic              err_clr
);

  // A misconfigured instance (address wider than the 32-bit range compare,
  // or an empty burst counter) never accepts anything.
  localparam logic        CFG_OK  = (ADDR_W <= 32) && (BURST_W > 0);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic              w_m0_req;
  logic              w_m1_req;
  logic              w_any;
  logic              w_win;      // 0 = m0, 1 = m1
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic              w_wr;
  logic              w_rd;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_oor;

  logic              r_last_grant;
  logic              r_tag_vld;
  logic              r_tag_id;
  logic              r_tag_oor;
  logic              r_range_err;

  assign w_m0_req = m0_read | m0_write;
  assign w_m1_req = m1_read | m1_write;

`ifdef ONCHIP_ARB_BURST_EN
  localparam logic [BURST_W-1:0] BC_ONE = BURST_W'(1);

  logic               r_lock;
  logic               r_lock_id;
  logic [BURST_W-1:0] r_left;     // beats still owed after the current one
  logic [BURST_W-1:0] w_bc;

  // While locked only the burst owner can be granted; if it drops its
  // request the port simply idles.
  always_comb begin
    if (r_lock) begin
      w_win = r_lock_id;
      w_any = r_lock_id ? w_m1_req : w_m0_req;
    end else begin
      w_win = w_m1_req & (~w_m0_req | ~r_last_grant);
      w_any = w_m0_req | w_m1_req;
    end
  end

  assign w_bc = w_win ? m1_burstcount : m0_burstcount;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
      r_left    <= '0;
    end else if (w_accept) begin
      if (r_lock) begin
        if (r_left == BC_ONE) begin
          r_lock <= 1'b0;
        end
        r_left <= r_left - BC_ONE;
      end else if (w_bc > BC_ONE) begin
        // burstcount 0 and 1 are single beats and never lock
        r_lock    <= 1'b1;
        r_lock_id <= w_win;
        r_left    <= w_bc - BC_ONE;
      end
    end
  end
`else
  // With both requesting, the master that was not granted last wins.
  assign w_win = w_m1_req & (~w_m0_req | ~r_last_grant);
  assign w_any = w_m0_req | w_m1_req;
`endif

  assign w_addr  = w_win ? m1_address    : m0_address;
  assign w_wr    = w_win ? m1_write      : m0_write;
  // read together with write is a write; the read is dropped
  assign w_rd    = (w_win ? m1_read : m0_read) & ~w_wr;
  assign w_be    = w_win ? m1_byteenable : m0_byteenable;
  assign w_wdata = w_win ? m1_writedata  : m0_writedata;
  assign w_oor   = 32'(w_addr) >= DEPTH_W;

  // Gating with reset_n keeps every stall high and the memory port quiet
  // while reset is asserted, even if masters are already requesting.
  assign w_accept = w_any & reset_n & CFG_OK;

  assign m0_waitrequest = ~(w_accept & ~w_win);
  assign m1_waitrequest = ~(w_accept &  w_win);

  assign mem_chipselect = w_accept & ~w_oor;
  assign mem_write      = w_accept & w_wr;
  assign mem_address    = w_accept ? w_addr  : '0;
  assign mem_byteenable = w_accept ? w_be    : 4'h0;
  assign mem_writedata  = w_accept ? w_wdata : 32'h0;
  assign mem_clken      = reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_tag_vld    <= 1'b0;
      r_tag_id     <= 1'b0;
      r_tag_oor    <= 1'b0;
      r_range_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_win;
      end
      r_tag_vld <= w_accept & w_rd;
      r_tag_id  <= w_win;
      r_tag_oor <= w_oor;
      if (w_accept & w_oor) begin
        r_range_err <= 1'b1;
      end else if (err_clr) begin
        r_range_err <= 1'b0;
      end
    end
  end

  assign range_err = r_range_err;

  // The memory's registered output lines up with the tag captured at the
  // same edge the address was clocked in.
  assign m0_readdatavalid = r_tag_vld & ~r_tag_id;
  assign m1_readdatavalid = r_tag_vld &  r_tag_id;
  assign m0_readdata = (m0_readdatavalid & ~r_tag_oor) ? mem_readdata : 32'h0;
  assign m1_readdata = (m1_readdatavalid & ~r_tag_oor) ? mem_readdata : 32'h0;

endmodule

// File: tb/tb_usb20sr_refdes_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for usb20sr_refdes_onchip_mem_arbiter. Structure: clock/reset block,
// a simple memory attached to the s2 port, a transaction-level reference
// model with a per-cycle compare process, driver tasks, directed scenarios,
// a randomized phase and a final report.
// ---------------------------------------------------------------------------
module tb_usb20sr_refdes_onchip_mem_arbiter;

  localparam int DEPTH  = 33750;
  localparam int ADDR_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [15:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
  logic        range_err;
  logic        err_clr;
`ifdef ONCHIP_ARB_BURST_EN
  logic [3:0]  m0_burstcount, m1_burstcount;
`endif

  usb20sr_refdes_onchip_mem_arbiter #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BURST_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
`ifdef ONCHIP_ARB_BURST_EN
    .m0_burstcount(m0_burstcount),
`endif
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
`ifdef ONCHIP_ARB_BURST_EN
    .m1_burstcount(m1_burstcount),
`endif
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .range_err(range_err), .err_clr(err_clr)
  );

  // ---------------- attached memory (registered read) ----------------
  logic [31:0] env_mem [65536];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) env_mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= env_mem[mem_address];
      end
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: who wins, what memory holds, which read is owed.
  logic [31:0] mdl_mem [65536];
  logic        m_last = 1'b1, m_pend_vld = 1'b0, m_pend_id = 1'b0, m_err = 1'b0;
  logic [31:0] m_pend_data = 32'h0;
  logic        nxt_last = 1'b1, nxt_pend_vld = 1'b0, nxt_pend_id = 1'b0, nxt_err = 1'b0;
  logic [31:0] nxt_pend_data = 32'h0;
  logic        nxt_wr_en = 1'b0;
  logic [15:0] nxt_wr_addr = 16'h0;
  logic [3:0]  nxt_wr_be = 4'h0;
  logic [31:0] nxt_wr_data = 32'h0;
  logic        m_lock = 1'b0, m_lock_id = 1'b0, nxt_lock = 1'b0, nxt_lock_id = 1'b0;
  int          m_left = 0, nxt_left = 0;

  // Compare process: every falling edge, outputs vs. model.
  always @(negedge clk) begin : cmp
    logic r0, r1, any, win, wr, rd, oor, e_v0, e_v1;
    logic [15:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    int          bc;
    e_v0 = m_pend_vld & ~m_pend_id;
    e_v1 = m_pend_vld &  m_pend_id;
    if (!reset_n) begin
      chk("rst_wait0", m0_waitrequest, 1);
      chk("rst_wait1", m1_waitrequest, 1);
      chk("rst_rdv0", m0_readdatavalid, 0);
      chk("rst_rdv1", m1_readdatavalid, 0);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_memw", mem_write, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_be", mem_byteenable, 0);
      chk("rst_wd", mem_writedata, 0);
      chk("rst_clken", mem_clken, 0);
      chk("rst_err", range_err, 0);
      nxt_last = 1'b1; nxt_pend_vld = 1'b0; nxt_err = 1'b0; nxt_wr_en = 1'b0;
      nxt_lock = 1'b0; nxt_left = 0;
    end else begin
      r0  = m0_read | m0_write;
      r1  = m1_read | m1_write;
      any = r0 | r1;
      win = r1 & (~r0 | ~m_last);
      if (m_lock) begin
        win = m_lock_id;
        any = m_lock_id ? r1 : r0;
      end
      a   = win ? m1_address : m0_address;
      wr  = win ? m1_write : m0_write;
      rd  = (win ? m1_read : m0_read) & ~wr;
      be  = win ? m1_byteenable : m0_byteenable;
      wd  = win ? m1_writedata : m0_writedata;
      oor = (int'(a) >= DEPTH);

      chk("wait0", m0_waitrequest, !(any && !win));
      chk("wait1", m1_waitrequest, !(any && win));
      chk("cs", mem_chipselect, any && !oor);
      chk("clken", mem_clken, 1);
      if (any) begin
        chk("mem_addr", mem_address, a);
        chk("mem_write", mem_write, wr);
        chk("mem_be", mem_byteenable, be);
        chk("mem_wd", mem_writedata, wd);
      end
      chk("rdv0", m0_readdatavalid, e_v0);
      chk("rdv1", m1_readdatavalid, e_v1);
      chk("rdata0", m0_readdata, e_v0 ? m_pend_data : 32'h0);
      chk("rdata1", m1_readdata, e_v1 ? m_pend_data : 32'h0);
      chk("range_err", range_err, m_err);

      nxt_last      = any ? win : m_last;
      nxt_pend_vld  = any & rd;
      nxt_pend_id   = win;
      nxt_pend_data = oor ? 32'h0 : mdl_mem[a];
      nxt_wr_en     = any & wr & ~oor;
      nxt_wr_addr   = a;
      nxt_wr_be     = be;
      nxt_wr_data   = wd;
      nxt_err       = (any & oor) ? 1'b1 : (err_clr ? 1'b0 : m_err);
      nxt_lock      = m_lock;
      nxt_lock_id   = m_lock_id;
      nxt_left      = m_left;
`ifdef ONCHIP_ARB_BURST_EN
      if (any) begin
        if (m_lock) begin
          nxt_left = m_left - 1;
          if (m_left == 1) nxt_lock = 1'b0;
        end else begin
          bc = int'(win ? m1_burstcount : m0_burstcount);
          if (bc == 0) bc = 1;
          if (bc > 1) begin
            nxt_lock = 1'b1; nxt_lock_id = win; nxt_left = bc - 1;
          end
        end
      end
`else
      bc = 0;
      if (bc != 0) nxt_left = bc;
`endif
    end
  end

  // Model state advance: same clock/reset as the design it predicts.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_last = 1'b1; m_pend_vld = 1'b0; m_err = 1'b0; m_lock = 1'b0; m_left = 0;
    end else begin
      m_last      = nxt_last;
      m_pend_vld  = nxt_pend_vld;
      m_pend_id   = nxt_pend_id;
      m_pend_data = nxt_pend_data;
      m_err       = nxt_err;
      m_lock      = nxt_lock;
      m_lock_id   = nxt_lock_id;
      m_left      = nxt_left;
      if (nxt_wr_en)
        for (int b = 0; b < 4; b++)
          if (nxt_wr_be[b]) mdl_mem[nxt_wr_addr][b*8 +: 8] = nxt_wr_data[b*8 +: 8];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_m(input int m, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_byteenable = be; m0_writedata = data;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_byteenable = be; m1_writedata = data;
    end
  endtask

  // Presents one transfer, holds it until accepted (bounded), then idles.
  // Returns just after the accepting clock edge.
  task automatic do_op(input int m, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
    bit done;
    done = 0;
    set_m(m, rd, wr, addr, be, data);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL do_op_timeout: master %0d never accepted addr %h", m, addr);
    end
    set_m(m, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
  endtask

  task automatic rand_op(output logic rd, output logic wr, output logic [15:0] addr,
                         output logic [3:0] be, output logic [31:0] data);
    int k;
    k = int'($urandom_range(0, 9));
    rd = (k >= 2 && k <= 5) || k == 8;
    wr = (k >= 6);
    case ($urandom_range(0, 7))
      0:       addr = 16'(DEPTH - 1);
      1:       addr = 16'(DEPTH);
      2:       addr = 16'hFFFF;
      3:       addr = 16'($urandom_range(0, 65535));
      default: addr = 16'(16'h0010 + $urandom_range(0, 7));
    endcase
    be   = 4'($urandom_range(0, 15));
    data = $urandom;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        rd, wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    bit          a0, a1;

    for (int i = 0; i < 65536; i++) begin
      data = $urandom;
      env_mem[i] = data;
      mdl_mem[i] = data;
    end
    reset_n = 1'b0;
    err_clr = 1'b0;
    set_m(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
`ifdef ONCHIP_ARB_BURST_EN
    m0_burstcount = 4'd0;
    m1_burstcount = 4'd0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_wait0", m0_waitrequest, 1);
    chk("lit_rst_rdv0", m0_readdatavalid, 0);
    chk("lit_rst_err", range_err, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: write then read back from m0
    do_op(0, 1'b0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
    do_op(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    @(negedge clk);
    chk("t1_rdv0", m0_readdatavalid, 1);
    chk("t1_rdata0", m0_readdata, 32'hDEADBEEF);
    chk("t1_rdv1", m1_readdatavalid, 0);
    @(posedge clk); #1;

    // 2: both masters read continuously; m1 wrote last so m0 wins first
    do_op(0, 1'b0, 1'b1, 16'h0020, 4'hF, 32'h1);
    do_op(1, 1'b0, 1'b1, 16'h0021, 4'hF, 32'h2);
    set_m(0, 1'b1, 1'b0, 16'h0020, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b0, 16'h0021, 4'hF, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_wait0", m0_waitrequest, k % 2);
      chk("t2_wait1", m1_waitrequest, (k + 1) % 2);
      if (k > 0) begin
        chk("t2_rdv0", m0_readdatavalid, ((k - 1) % 2) == 0);
        chk("t2_rdv1", m1_readdatavalid, ((k - 1) % 2) == 1);
        chk("t2_rdata0", m0_readdata, ((k - 1) % 2) == 0 ? 32'h1 : 32'h0);
        chk("t2_rdata1", m1_readdata, ((k - 1) % 2) == 1 ? 32'h2 : 32'h0);
      end
      @(posedge clk); #1;
    end
    set_m(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);

    // 3: partial-byte write from m1
    do_op(1, 1'b0, 1'b1, 16'h0030, 4'hF, 32'hFFFFFFFF);
    do_op(1, 1'b0, 1'b1, 16'h0030, 4'h3, 32'h12345678);
    do_op(1, 1'b1, 1'b0, 16'h0030, 4'hF, 32'h0);
    @(negedge clk);
    chk("t3_rdv1", m1_readdatavalid, 1);
    chk("t3_rdata1", m1_readdata, 32'hFFFF5678);
    @(posedge clk); #1;

    // 4: out-of-range read, then clear the error
    set_m(0, 1'b1, 1'b0, 16'(DEPTH), 4'hF, 32'h0);
    @(negedge clk);
    chk("t4_wait0", m0_waitrequest, 0);
    chk("t4_cs", mem_chipselect, 0);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t4_rdv0", m0_readdatavalid, 1);
    chk("t4_rdata0", m0_readdata, 0);
    chk("t4_err", range_err, 1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("t4_err_clr", range_err, 0);
    @(posedge clk); #1;

    // 5: reset during the return cycle of an accepted read
    do_op(1, 1'b0, 1'b1, 16'h0011, 4'hF, 32'h5);   // leaves last_grant = m1 ... then reset restores it
    do_op(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    reset_n = 1'b0;
    set_m(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    @(negedge clk);
    chk("t5_rdv0_rst", m0_readdatavalid, 0);
    chk("t5_wait0_rst", m0_waitrequest, 1);
    chk("t5_cs_rst", mem_chipselect, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_m(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t5_rdv0_after", m0_readdatavalid, 0);
    @(posedge clk); #1;
    set_m(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b0, 16'h0011, 4'hF, 32'h0);
    @(negedge clk);
    chk("t5_grant_m0", m0_waitrequest, 0);
    chk("t5_hold_m1", m1_waitrequest, 1);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);

`ifdef ONCHIP_ARB_BURST_EN
    // 6: m1 bursts 4 beats while m0 keeps requesting (m0 won last)
    m1_burstcount = 4'd4;
    set_m(1, 1'b1, 1'b0, 16'h0020, 4'hF, 32'h0);
    set_m(0, 1'b1, 1'b0, 16'h0021, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_burst_m1", m1_waitrequest, 0);
      chk("t6_burst_m0", m0_waitrequest, 1);
      @(posedge clk); #1;
    end
    m1_burstcount = 4'd1;
    @(negedge clk);
    chk("t6_after_m0", m0_waitrequest, 0);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    m1_burstcount = 4'd0;
`endif

    // randomized traffic; masters hold requests while stalled
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a0 = !m0_waitrequest;
      a1 = !m1_waitrequest;
      @(posedge clk); #1;
      if (!(m0_read | m0_write) || a0) begin
        rand_op(rd, wr, addr, be, data);
        set_m(0, rd, wr, addr, be, data);
`ifdef ONCHIP_ARB_BURST_EN
        m0_burstcount = 4'($urandom_range(0, 4));
`endif
      end
      if (!(m1_read | m1_write) || a1) begin
        rand_op(rd, wr, addr, be, data);
        set_m(1, rd, wr, addr, be, data);
`ifdef ONCHIP_ARB_BURST_EN
        m1_burstcount = 4'($urandom_range(0, 4));
`endif
      end
      err_clr = ($urandom_range(0, 9) == 0);
    end
    set_m(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/usb20sr_refdes_onchip_mem_arbiter.md
Name: usb20sr_refdes_onchip_mem_arbiter

Overview:
Round-robin arbiter that shares the second (s2) port of the 32-bit on-chip memory between two Avalon-MM masters: the ULPI RX DMA (m0) and the ULPI TX DMA (m1).
- Pipelined: one transfer per clock, read data returned one cycle after issue.
- Out-of-range addresses are range-checked and reported as errors.
- Sits between the USB DMA engines and the memory's address2/chipselect2/write2 port.

Parameters:
DEPTH, 33750, number of 32-bit words implemented in the memory; valid addresses are 0..DEPTH-1
ADDR_W, 16, word address width
BURST_W, 4, burstcount width (used only when ONCHIP_ARB_BURST_EN is defined)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  master 0 word address
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_byteenable  in  4  master 0 byte lanes
m0_writedata  in  32  master 0 write data
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  32  master 0 read data
m0_readdatavalid  out  1  master 0 read data strobe
m1_*  same set as m0_*  master 1
mem_address  out  ADDR_W  to memory address2
mem_chipselect  out  1  to chipselect2
mem_write  out  1  to write2
mem_byteenable  out  4  to byteenable2
mem_writedata  out  32  to writedata2
mem_clken  out  1  to clken2
mem_readdata  in  32  from readdata2 (valid the cycle after address is clocked)
range_err  out  1  sticky out-of-range flag
err_clr  in  1  clears range_err

Behaviour:
- Reset (async, reset_n=0):
  - last_grant=1, so m0 wins the first contention.
  - Read tag pipeline cleared; range_err=0.
  - Both readdatavalid=0, both waitrequest=1; all mem_* outputs 0 except mem_clken.
  - mem_clken=1 whenever reset_n=1.
- Request: mX_req = mX_read | mX_write. Read and write together is treated as a write; the read is dropped.
- Arbitration (combinational in the same cycle):
  - Only one requester: it wins.
  - Both request: the one not equal to last_grant wins.
  - last_grant updates on the clock edge whenever a transfer is accepted.
- Accept: winner's waitrequest=0 in that cycle; loser's waitrequest=1.
  - Masters hold signals stable while waitrequest=1.
  - waitrequest=1 is also driven when there is no request.
- Issue: mem_* driven combinationally from the winner.
  - mem_chipselect=1 only for accepted in-range transfers.
  - mem_write = winner write.
- Range check: address >= DEPTH.
  - Write: chipselect suppressed (write dropped); range_err set.
  - Read: no memory access; the winner still receives readdatavalid the next cycle with readdata=0; range_err set.
- Read return:
  - A registered tag {valid, id, oor} captures each accepted read.
  - Next cycle, mX_readdatavalid=1 for the tagged id only.
  - mX_readdata = mem_readdata, or 0 if oor; 0 for the non-tagged master.
- Throughput:
  - Back-to-back reads from alternating masters sustain 1 transfer/clk with no bubbles.
  - Read-after-write to the same address from either master returns the new data (write lands at edge N, read issued at N+1).
- range_err: set has priority over err_clr in the same cycle.
- Reset mid-transfer: an outstanding readdatavalid is cancelled and never emitted after reset release.

Optional Feature:
Macro ONCHIP_ARB_BURST_EN.
- Defined:
  - Ports m0_burstcount and m1_burstcount (BURST_W, value 0 treated as 1) are added.
  - On the first accepted beat, the grant locks to that master for burstcount accepted beats; the other master sees waitrequest=1 throughout.
  - The master supplies each beat's address; beats are not auto-incremented.
  - Lock releases after the last beat; last_grant = bursting master.
  - A beat not presented while locked causes idle cycles, never a grant switch.
- Undefined: burstcount ports are absent; every beat is arbitrated independently.

Test Plan:
1. After reset, m0 writes 0xDEADBEEF to addr 0x10 with byteenable 0xF, then reads 0x10 -> m0_readdatavalid one cycle after accept, m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
2. m0 and m1 both read continuously (addr 0x20 and 0x21 preloaded to 1 and 2) -> grants alternate m0,m1,m0,...; one accept per clk; each readdatavalid carries its own word.
3. m1 writes byteenable 0x3 data 0x12345678 over 0xFFFFFFFF -> readback 0xFFFF5678.
4. m0 read at addr 33750 -> readdatavalid next cycle, readdata=0, mem_chipselect never 1, range_err=1; err_clr=1 -> range_err=0.
5. Read accepted, reset_n pulsed low before the return cycle -> no readdatavalid after release; next contention grants m0.
6. (ONCHIP_ARB_BURST_EN) m1 burstcount=4 while m0 requests -> m1 receives 4 consecutive accepts, m0 waitrequest=1 throughout, then m0 granted.
